coin_acceptor_frontend: RTL and testbench
=========================================

Name: coin_acceptor_frontend

Overview:
Upstream stage of the ticket vending FSM. It converts two raw, asynchronous coin-sensor lines into clean single-cycle coin codes on the 2-bit coin bus that the vending FSM consumes: 00 = none, 01 = one unit, 10 = two units. It synchronises and debounces the sensors, rejects jams and coins offered while disabled, enforces a hold-off between coins, and keeps a running accepted-coin count for the service display.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised samples a sensor pattern must hold before it is qualified (legal range 2..255).
HOLDOFF_CYCLES, 8, dead cycles after sensor release before a new coin is looked for (legal range 1..255).
CNT_W, 8, width of coin_total.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sense_one  in  1  raw one-unit coin sensor, asynchronous, high = coin present
sense_two  in  1  raw two-unit coin sensor, asynchronous, high = coin present
accept_en  in  1  synchronous; 1 = coins may be accepted, 0 = coins are rejected
coin  out  2  registered coin code to the vending FSM; never 11
reject  out  1  registered one-cycle pulse: coin returned (jam, or accept_en low)
busy  out  1  registered; high whenever the FSM is not in IDLE
coin_total  out  CNT_W  registered count of accepted coins, wraps modulo 2^CNT_W

Behaviour:
- Reset: clk and rst are as stated above; rst is asynchronous and active-high. While rst is high: coin=00, reject=0, busy=0, coin_total=0, both synchroniser stages=0, state=IDLE, debounce and hold-off counters=0. Reset mid-operation aborts any pending coin with no output.
- Synchroniser: each sensor passes through a 2-flop synchroniser. pat = {sync_two, sync_one} is the only view the FSM uses.
- The states are IDLE, DEBOUNCE, WAIT_RELEASE and HOLDOFF.
- IDLE: if pat != 00, latch pat, set cnt=1 and go to DEBOUNCE.
- DEBOUNCE, pattern changed: if pat != latched pattern (including 00), return to IDLE. There is no output; this is a glitch.
- DEBOUNCE, pattern stable: if pat == latched pattern and cnt < DEBOUNCE_CYCLES-1, increment cnt.
- DEBOUNCE, qualified: if pat == latched pattern and cnt == DEBOUNCE_CYCLES-1, the pattern is qualified and the FSM goes to WAIT_RELEASE. On that same edge:
  - latched 01 and accept_en=1: coin<=01, coin_total<=coin_total+1.
  - latched 10 and accept_en=1: coin<=10, coin_total<=coin_total+1.
  - latched 11 (both sensors, a jam) or accept_en=0: reject<=1, coin stays 00, count unchanged.
- WAIT_RELEASE: stay until pat == 00, then set the hold-off counter to 0 and go to HOLDOFF. A held sensor never produces a second coin.
- HOLDOFF: count HOLDOFF_CYCLES cycles, then go to IDLE. Sensor activity during HOLDOFF is ignored; a sensor still high on return to IDLE starts a new DEBOUNCE.
- Output pulse width: coin and reject are each high for exactly one cycle per qualification. They are never high together.
- Latency: let N be the first clk edge that samples a raw sensor high, with the sensor held stable. coin or reject is registered at edge N+1+DEBOUNCE_CYCLES. With the default of 4, that is edge N+5.
- accept_en is sampled only on the qualifying edge. Changes at any other time have no effect.
- coin_total wraps from 2^CNT_W-1 to 0 with no flag.
- busy<=1 on any transition out of IDLE and busy<=0 on the transition into IDLE, so it is registered with no combinational path.

Test Plan:
1. sense_one high for 20 cycles from edge N, accept_en=1, defaults -> coin=01 only in the cycle after edge N+5; coin_total 0->1; no further coin while sensor held; busy returns to 0 8 cycles after release+sync.
2. sense_two high 10 cycles -> coin=10 for one cycle at edge N+5; coin_total increments; then sense_one pulse after hold-off -> coin=01, coin_total=2.
3. sense_one high for 2 cycles then low (glitch shorter than DEBOUNCE_CYCLES) -> coin stays 00, reject stays 0, coin_total unchanged, busy falls back to 0.
4. sense_one and sense_two raised on the same cycle, held 10 cycles -> reject=1 for one cycle at edge N+5, coin=00, coin_total unchanged. Repeat with sense_one only and accept_en=0 -> reject pulse, no coin.
5. sense_one held, rst pulsed at edge N+3 -> coin never asserts, all outputs 0. After rst release, with the sensor still high, a fresh qualification yields coin=01 at release+1+DEBOUNCE_CYCLES.
6. CNT_W=2, 5 accepted coins separated by hold-off -> coin_total sequence 1,2,3,0,1. A second coin inserted during HOLDOFF and held is accepted only after hold-off expires plus the debounce delay.

Source files
------------

// File: rtl/coin_acceptor_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : coin_acceptor_frontend
//  Purpose  : Front end for the ticket vending FSM. Synchronises and
//             debounces two raw coin sensors and emits single-cycle coin
//             codes (00 none, 01 one unit, 10 two units). Jams (both
//             sensors) and coins offered while disabled produce a reject
//             pulse instead. A hold-off follows each sensor release, and a
//             wrapping count of accepted coins drives the service display.
//  Ports    : clk          system clock
//             rst          asynchronous active-high reset
//             sense_one    raw one-unit sensor (asynchronous)
//             sense_two    raw two-unit sensor (asynchronous)
//             accept_en    1 = accept coins, 0 = reject them
//             coin         registered single-cycle coin code, never 11
//             reject       registered single-cycle coin-returned pulse
//             busy         registered, high whenever the FSM is not IDLE
//             coin_total   registered wrapping accepted-coin count
//  Revision : 1.0  initial release
// ============================================================================
module coin_acceptor_frontend #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sense_one,
    input  logic             sense_two,
    input  logic             accept_en,
    output logic [1:0]       coin,
    output logic             reject,
    output logic             busy,
    output logic [CNT_W-1:0] coin_total
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_WAIT_REL = 2'd2;
    localparam logic [1:0] c_HOLDOFF  = 2'd3;

    localparam logic [7:0] c_DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] c_HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);

    // Two-flop synchronisers, one per sensor
    logic r_one_s1, r_one_s2, r_two_s1, r_two_s2;

    logic [1:0]       r_state;
    logic [1:0]       r_latched;
    logic [7:0]       r_dcnt;
    logic [7:0]       r_hcnt;
    logic [1:0]       r_coin;
    logic             r_reject;
    logic             r_busy;
    logic [CNT_W-1:0] r_total;

    logic [1:0]       w_pat;
    logic [1:0]       w_state_nxt;
    logic             w_qualify;
    logic [1:0]       w_latched_nxt;
    logic [7:0]       w_dcnt_nxt;
    logic [7:0]       w_hcnt_nxt;
    logic [1:0]       w_coin_nxt;
    logic             w_reject_nxt;
    logic             w_busy_nxt;
    logic [CNT_W-1:0] w_total_nxt;

    assign w_pat = {r_two_s2, r_one_s2};

    // Pattern has held for the full debounce window on this edge
    assign w_qualify = (r_state == c_DEBOUNCE) && (w_pat == r_latched) &&
                       (r_dcnt == c_DEB_LAST);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_one_s1  <= 1'b0;
            r_one_s2  <= 1'b0;
            r_two_s1  <= 1'b0;
            r_two_s2  <= 1'b0;
            r_state   <= c_IDLE;
            r_latched <= 2'b00;
            r_dcnt    <= 8'd0;
            r_hcnt    <= 8'd0;
            r_coin    <= 2'b00;
            r_reject  <= 1'b0;
            r_busy    <= 1'b0;
            r_total   <= '0;
        end else begin
            r_one_s1  <= sense_one;
            r_one_s2  <= r_one_s1;
            r_two_s1  <= sense_two;
            r_two_s2  <= r_two_s1;
            r_state   <= w_state_nxt;
            r_latched <= w_latched_nxt;
            r_dcnt    <= w_dcnt_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_coin    <= w_coin_nxt;
            r_reject  <= w_reject_nxt;
            r_busy    <= w_busy_nxt;
            r_total   <= w_total_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_pat != 2'b00) w_state_nxt = c_DEBOUNCE;
            end
            c_DEBOUNCE: begin
                // Any change, including release, is treated as a glitch
                if (w_pat != r_latched)        w_state_nxt = c_IDLE;
                else if (r_dcnt == c_DEB_LAST) w_state_nxt = c_WAIT_REL;
            end
            c_WAIT_REL: begin
                if (w_pat == 2'b00) w_state_nxt = c_HOLDOFF;
            end
            c_HOLDOFF: begin
                if (r_hcnt == c_HOLD_LAST) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output and counter logic (all results are registered above)
    // ------------------------------------------------------------------
    always_comb begin
        w_latched_nxt = r_latched;
        w_dcnt_nxt    = r_dcnt;
        w_hcnt_nxt    = r_hcnt;
        w_coin_nxt    = 2'b00;
        w_reject_nxt  = 1'b0;
        w_total_nxt   = r_total;
        // busy tracks the state being entered, so it stays purely registered
        w_busy_nxt    = (w_state_nxt != c_IDLE);

        case (r_state)
            c_IDLE: begin
                if (w_pat != 2'b00) begin
                    w_latched_nxt = w_pat;
                    w_dcnt_nxt    = 8'd1;
                end
            end
            c_DEBOUNCE: begin
                if (w_qualify) begin
                    // accept_en matters only on this qualifying edge
                    if ((r_latched == 2'b11) || !accept_en) begin
                        w_reject_nxt = 1'b1;
                    end else begin
                        w_coin_nxt  = r_latched;
                        w_total_nxt = r_total + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else if (w_pat == r_latched) begin
                    w_dcnt_nxt = r_dcnt + 8'd1;
                end
            end
            c_WAIT_REL: begin
                if (w_pat == 2'b00) w_hcnt_nxt = 8'd0;
            end
            c_HOLDOFF: begin
                if (r_hcnt != c_HOLD_LAST) w_hcnt_nxt = r_hcnt + 8'd1;
            end
            default: begin
                w_dcnt_nxt = 8'd0;
            end
        endcase
    end

    assign coin       = r_coin;
    assign reject     = r_reject;
    assign busy       = r_busy;
    assign coin_total = r_total;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : tb_coin_acceptor_frontend
//  Purpose  : Self-checking bench. Two instances share one stimulus stream:
//             a default instance and a small one (DEBOUNCE 2, HOLDOFF 3,
//             CNT_W 2) that exercises the shortest debounce and count wrap.
//             Directed table vectors, randomized runs checked against an
//             event-scanning reference model, and a mid-qualification reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_coin_acceptor_frontend;

    localparam int MAXL = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sense_one = 1'b0;
    logic       sense_two = 1'b0;
    logic       accept_en = 1'b1;
    logic [1:0] coin1, coin2;
    logic       rej1, rej2, busy1, busy2;
    logic [7:0] tot1;
    logic [1:0] tot2;

    coin_acceptor_frontend #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(8), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .sense_one(sense_one), .sense_two(sense_two),
        .accept_en(accept_en), .coin(coin1), .reject(rej1), .busy(busy1),
        .coin_total(tot1)
    );

    coin_acceptor_frontend #(.DEBOUNCE_CYCLES(2), .HOLDOFF_CYCLES(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .sense_one(sense_one), .sense_two(sense_two),
        .accept_en(accept_en), .coin(coin2), .reject(rej2), .busy(busy2),
        .coin_total(tot2)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- stimulus / response log ----------------
    logic       log_on = 1'b0;
    int         n_log  = 0;
    logic [1:0] l_raw [MAXL];
    logic       l_en  [MAXL];
    int l1_coin [MAXL], l1_rej [MAXL], l1_busy [MAXL], l1_tot [MAXL];
    int l2_coin [MAXL], l2_rej [MAXL], l2_busy [MAXL], l2_tot [MAXL];

    always @(posedge clk) begin
        if (log_on && n_log < MAXL) begin
            l_raw[n_log] = {sense_two, sense_one};
            l_en[n_log]  = accept_en;
            #1;
            l1_coin[n_log] = int'(coin1); l1_rej[n_log] = int'(rej1);
            l1_busy[n_log] = int'(busy1); l1_tot[n_log] = int'(tot1);
            l2_coin[n_log] = int'(coin2); l2_rej[n_log] = int'(rej2);
            l2_busy[n_log] = int'(busy2); l2_tot[n_log] = int'(tot2);
            n_log++;
        end
    end

    // ---------------- reference model ----------------
    // Expected outputs after each logged edge, derived by scanning the
    // synchronised pattern history for qualification windows.
    int e_coin [MAXL], e_rej [MAXL], e_busy [MAXL], e_tot [MAXL];

    // The pattern seen at edge k is the raw value sampled two edges earlier
    function automatic int pat_at(input int k);
        return (k >= 2) ? int'(l_raw[k-2]) : 0;
    endfunction

    task automatic run_model(input int D, input int H, input int W, input int n);
        int e, k, j, q, r, ex, p, tot;
        for (int t = 0; t < n; t++) begin
            e_coin[t] = 0; e_rej[t] = 0; e_busy[t] = 0;
        end
        e = 0;
        while (e < n) begin
            k = e;
            while (k < n && pat_at(k) == 0) k++;
            if (k >= n) break;
            p = pat_at(k);
            j = 1;
            while (j < D && (k + j) < n && pat_at(k + j) == p) j++;
            if (j < D) begin
                ex = k + j;
                for (int t = k; t < ex && t < n; t++) e_busy[t] = 1;
                e = ex + 1;
                continue;
            end
            q = k + D - 1;
            if (p == 3 || !l_en[q]) e_rej[q] = 1;
            else                    e_coin[q] = p;
            r = q + 1;
            while (r < n && pat_at(r) != 0) r++;
            ex = r + H;
            for (int t = k; t < ex && t < n; t++) e_busy[t] = 1;
            e = ex + 1;
        end
        tot = 0;
        for (int t = 0; t < n; t++) begin
            if (e_coin[t] != 0) tot = (tot + 1) % (1 << W);
            e_tot[t] = tot;
        end
    endtask

    task automatic compare_dut(input int which, input int n);
        int ac, ar, ab, at;
        for (int t = 0; t < n; t++) begin
            ac = (which == 1) ? l1_coin[t] : l2_coin[t];
            ar = (which == 1) ? l1_rej[t]  : l2_rej[t];
            ab = (which == 1) ? l1_busy[t] : l2_busy[t];
            at = (which == 1) ? l1_tot[t]  : l2_tot[t];
            chk($sformatf("dut%0d coin @%0d", which, t), ac, e_coin[t]);
            chk($sformatf("dut%0d reject @%0d", which, t), ar, e_rej[t]);
            chk($sformatf("dut%0d busy @%0d", which, t), ab, e_busy[t]);
            chk($sformatf("dut%0d total @%0d", which, t), at, e_tot[t]);
        end
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while ((busy1 || busy2) && waited < 80) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("idle_wait", int'(busy1 | busy2), 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0] pat;
        int         hold;
        bit         en;
        int         exp_coin;
        bit         exp_rej;
        int         exp_lat;   // edge offset of the pulse, -1 = no pulse
    } vec_t;

    vec_t tbl [8];

    initial begin
        int nev, lat, c, rj, t_exp, lat1, lat2, c1, c2;

        tbl[0] = '{pat: 2'b01, hold: 20, en: 1'b1, exp_coin: 1, exp_rej: 1'b0, exp_lat: 5};
        tbl[1] = '{pat: 2'b10, hold: 10, en: 1'b1, exp_coin: 2, exp_rej: 1'b0, exp_lat: 5};
        tbl[2] = '{pat: 2'b01, hold: 4,  en: 1'b1, exp_coin: 1, exp_rej: 1'b0, exp_lat: 5};
        tbl[3] = '{pat: 2'b01, hold: 2,  en: 1'b1, exp_coin: 0, exp_rej: 1'b0, exp_lat: -1};
        tbl[4] = '{pat: 2'b10, hold: 3,  en: 1'b1, exp_coin: 0, exp_rej: 1'b0, exp_lat: -1};
        tbl[5] = '{pat: 2'b11, hold: 10, en: 1'b1, exp_coin: 0, exp_rej: 1'b1, exp_lat: 5};
        tbl[6] = '{pat: 2'b01, hold: 10, en: 1'b0, exp_coin: 0, exp_rej: 1'b1, exp_lat: 5};
        tbl[7] = '{pat: 2'b10, hold: 6,  en: 1'b1, exp_coin: 2, exp_rej: 1'b0, exp_lat: 5};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset coin", int'(coin1), 0);
        chk("reset reject", int'(rej1), 0);
        chk("reset busy", int'(busy1), 0);
        chk("reset total", int'(tot1), 0);
        chk("reset total dut2", int'(tot2), 0);
        @(negedge clk);
        rst    = 1'b0;
        log_on = 1'b1;

        // Directed vectors, expectations for the default instance
        t_exp = 0;
        for (int v = 0; v < 8; v++) begin
            wait_idle();
            @(negedge clk);
            {sense_two, sense_one} = tbl[v].pat;
            accept_en = tbl[v].en;
            nev = 0; lat = -1; c = 0; rj = 0;
            for (int o = 0; o < 30; o++) begin
                @(posedge clk); #1;
                if (coin1 != 2'b00 || rej1) begin
                    nev++; lat = o; c = int'(coin1); rj = int'(rej1);
                end
                @(negedge clk);
                if (o == tbl[v].hold - 1) {sense_two, sense_one} = 2'b00;
            end
            accept_en = 1'b1;
            if (tbl[v].exp_coin != 0) t_exp++;
            chk($sformatf("vec%0d events", v), nev, (tbl[v].exp_lat >= 0) ? 1 : 0);
            chk($sformatf("vec%0d coin", v), c, tbl[v].exp_coin);
            chk($sformatf("vec%0d reject", v), rj, int'(tbl[v].exp_rej));
            chk($sformatf("vec%0d latency", v), lat, tbl[v].exp_lat);
            chk($sformatf("vec%0d total", v), int'(tot1), t_exp);
        end

        // Randomized runs of sensor patterns
        begin
            int cyc, r, hold;
            logic [1:0] p;
            cyc = 0;
            while (cyc < 1500) begin
                r = $urandom_range(0, 9);
                p = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
                hold = $urandom_range(1, 14);
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    {sense_two, sense_one} = p;
                    accept_en = ($urandom_range(0, 99) < 85);
                    cyc++;
                end
            end
            @(negedge clk);
            {sense_two, sense_one} = 2'b00;
            accept_en = 1'b1;
            repeat (40) @(posedge clk);
            @(negedge clk);
            log_on = 1'b0;
            #1;
        end

        run_model(4, 8, 8, n_log);
        compare_dut(1, n_log);
        run_model(2, 3, 2, n_log);
        compare_dut(2, n_log);

        // Reset while a coin is being debounced, sensor kept high
        wait_idle();
        @(negedge clk);
        sense_one = 1'b1;
        for (int o = 0; o < 3; o++) begin
            @(posedge clk); #1;
            chk($sformatf("pre-rst coin1 @%0d", o), int'(coin1) | int'(rej1), 0);
            chk($sformatf("pre-rst coin2 @%0d", o), int'(coin2) | int'(rej2), 0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst async busy1", int'(busy1), 0);
        chk("rst async total1", int'(tot1), 0);
        @(posedge clk); #1;
        chk("rst edge coin1", int'(coin1) | int'(rej1), 0);
        chk("rst edge coin2", int'(coin2) | int'(rej2), 0);
        chk("rst edge total2", int'(tot2), 0);
        @(negedge clk);
        rst = 1'b0;
        lat1 = -1; lat2 = -1; c1 = 0; c2 = 0;
        for (int o = 0; o < 10; o++) begin
            @(posedge clk); #1;
            if (coin1 != 2'b00 || rej1) begin lat1 = o; c1 = int'(coin1); end
            if (coin2 != 2'b00 || rej2) begin lat2 = o; c2 = int'(coin2); end
        end
        @(negedge clk);
        sense_one = 1'b0;
        chk("post-rst latency1", lat1, 5);
        chk("post-rst coin1", c1, 1);
        chk("post-rst latency2", lat2, 3);
        chk("post-rst coin2", c2, 1);
        chk("post-rst total1", int'(tot1), 1);
        chk("post-rst total2", int'(tot2), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
